ex_mul_seq: RTL and testbench
=============================

// Module: ex_mul_seq
// PURPOSE
//  Multi-cycle 16x16 shift-add multiply sequencer that borrows the EX-stage ALU.
//  Owns the ALU operand/op port while a multiply runs; passes pipeline operands through otherwise.
//  Stalls the front of the pipeline until the 16-bit product is ready.
//  Sits in the EX stage between the ID/EX pipeline register and the ALU.
// PARAMETERS
//  WIDTH  16  datapath width; the ALU is 16 bits, only 16 is supported
//  CNT_W  4   iteration counter width, log2(WIDTH)
// PORTS
//  clk         in   1      single clock, all state updates on rising edge
//  rst         in   1      synchronous, active-high reset
//  start       in   1      EX holds a MUL instruction; held high until the pipeline advances
//  mul_a       in   16     multiplicand
//  mul_b       in   16     multiplier
//  pipe_a      in   16     normal ALU operand A from ID/EX
//  pipe_b      in   16     normal ALU operand B from ID/EX
//  pipe_op     in   3      normal ALU operation, alu_op_t
//  pipe_shamt  in   4      normal ALU shift amount
//  alu_a       out  16     to ALU input a
//  alu_b       out  16     to ALU input b
//  alu_op      out  3      to ALU operation
//  alu_shamt   out  4      to ALU shamt
//  alu_result  in   16     from ALU result
//  stall       out  1      hold IF/ID/EX (combinational)
//  done        out  1      one-cycle pulse, product valid
//  product     out  16     low 16 bits of a*b, registered
//  mul_ovf     out  1      unsigned product exceeds 16 bits, valid with done
// BEHAVIOUR
//  States: IDLE, RUN, DONE. Reset: state=IDLE; product=0; mul_ovf=0; done=0; internal regs=0.
//  A reset in any state, including mid-RUN, aborts the multiply and returns to IDLE.
//  IDLE & start: load acc=0, mcand=mul_a, mplier=mul_b, cnt=0, ovf=0; go to RUN.
//  RUN, each cycle:
//   - ALU driven with a=acc, b=mcand, op=ADD, shamt=0.
//   - if mplier[0]: acc <= alu_result.
//   - mcand <= mcand<<1; mplier <= mplier>>1; cnt++.
//   - ovf sticky set if (mplier[0] & alu_result<acc) | (mcand[15] & mplier[15:1]!=0).
//  RUN exit: go to DONE when mplier[15:1]==0 or cnt==15; the final add is still applied.
//  Number of RUN cycles = max(1, msb_index(mul_b)+1), range 1..16.
//  DONE, one cycle: done=1; product=acc and mul_ovf=ovf are visible this cycle and held afterwards;
//   then go to IDLE.
//  product and mul_ovf hold their value until the next DONE or a reset.
//  stall = (IDLE & start) | RUN. stall is low in DONE so the MUL retires with the product.
//  start in RUN or DONE is ignored. Back-to-back MULs: the next one is accepted on the
//   IDLE cycle after DONE.
//  Latency: start accepted at edge 0; done is high in cycle N+1, where N = number of RUN cycles.
//  ALU port mux: RUN -> sequencer values; IDLE/DONE -> pipe_* passed through unchanged.
//  Signed operands give the correct low 16 bits (two's complement).
//  mul_ovf is meaningful for unsigned operands only.
// STRUCTURE
//  alu_pkg: alu_op_t enum (ADD=0, SUB, NAND, XOR, NOR, SLL, SRL, SRA); mul_state_t enum;
//   WIDTH constant. Shared with the ALU and decode.
//  One sub-module: alu_port_mux (combinational 2:1 mux of {a,b,op,shamt}, select = state==RUN).
//  FSM, counter, acc/mcand/mplier registers and ovf tracking live in ex_mul_seq.
// TESTING
//  1. a=3, b=5, start held -> 3 RUN cycles; done in cycle 4; product=0x000F; mul_ovf=0.
//  2. a=0x00FF, b=0x0101 -> product=0xFFFF; mul_ovf=0; 9 RUN cycles.
//  3. a=0x8000, b=2 -> product=0x0000; mul_ovf=1; 2 RUN cycles.
//  4. b=0 (any a) -> 1 RUN cycle; done in cycle 2; product=0; stall high exactly 2 cycles.
//  5. a=0xFFFF, b=0x8000; assert rst in 5th RUN cycle -> next cycle state IDLE, stall=0,
//     done=0, product=0; a fresh start then runs to completion.
//  6. Idle passthrough: start=0, pipe_op=SUB, pipe_a=7, pipe_b=2 -> alu_* equal pipe_*; stall=0;
//     then back-to-back MULs 6*7 and 0xFFFF*0xFFFF -> products 0x002A, 0x0001, ovf 0, 1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation encodings, multiply sequencer states and datapath width
package alu_pkg;
  localparam int WIDTH = 16;
  typedef enum logic [2:0] {ADD, SUB, NAND, XOR, NOR, SLL, SRL, SRA} alu_op_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
endpackage

// File: rtl/alu_port_mux.sv
// alu_port_mux: selects sequencer or pipeline values onto the ALU operand/op port
module alu_port_mux #(
  parameter int W = 16
) (
  input  logic         sel,
  input  logic [W-1:0] run_a,
  input  logic [W-1:0] run_b,
  input  logic [2:0]   run_op,
  input  logic [3:0]   run_shamt,
  input  logic [W-1:0] pipe_a,
  input  logic [W-1:0] pipe_b,
  input  logic [2:0]   pipe_op,
  input  logic [3:0]   pipe_shamt,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  output logic [3:0]   alu_shamt
);
  always_comb begin
    alu_a     = sel ? run_a     : pipe_a;
    alu_b     = sel ? run_b     : pipe_b;
    alu_op    = sel ? run_op    : pipe_op;
    alu_shamt = sel ? run_shamt : pipe_shamt;
  end
endmodule

// File: rtl/ex_mul_seq.sv
// ex_mul_seq: multi-cycle shift-add multiplier borrowing the EX-stage ALU, stalling the front end
module ex_mul_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] mul_a,
  input  logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] pipe_a,
  input  logic [WIDTH-1:0] pipe_b,
  input  logic [2:0]       pipe_op,
  input  logic [3:0]       pipe_shamt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic [3:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_result,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             mul_ovf
);
  import alu_pkg::*;
  mul_state_t state;
  logic [WIDTH-1:0] acc, mcand, mplier, acc_n;
  logic [CNT_W-1:0] cnt;
  logic ovf, ovf_n, last;
  always_comb begin
    acc_n = mplier[0] ? alu_result : acc;
    ovf_n = ovf | (mplier[0] & (alu_result < acc)) | (mcand[WIDTH-1] & |mplier[WIDTH-1:1]);
    last  = ~|mplier[WIDTH-1:1] | (cnt == CNT_W'(WIDTH - 1));
    stall = (state == IDLE && start) || state == RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mul_ovf <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        acc    <= '0;
        mcand  <= mul_a;
        mplier <= mul_b;
        cnt    <= '0;
        ovf    <= 1'b0;
        state  <= RUN;
      end else if (state == RUN) begin
        acc    <= acc_n;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        ovf    <= ovf_n;
        if (last) begin
          state   <= DONE;
          done    <= 1'b1;
          product <= acc_n;
          mul_ovf <= ovf_n;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
  alu_port_mux #(.W(WIDTH)) u_mux (
    .sel(state == RUN),
    .run_a(acc),
    .run_b(mcand),
    .run_op(ADD),
    .run_shamt(4'd0),
    .pipe_a(pipe_a),
    .pipe_b(pipe_b),
    .pipe_op(pipe_op),
    .pipe_shamt(pipe_shamt),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .alu_shamt(alu_shamt)
  );
endmodule

// File: tb/tb_ex_mul_seq.sv
// tb_ex_mul_seq: directed checks of the multiply sequencer against hand-computed results
module tb_ex_mul_seq;
  logic clk = 0, rst = 1, start = 0;
  logic [15:0] mul_a = 0, mul_b = 0, pipe_a = 0, pipe_b = 0;
  logic [2:0] pipe_op = 0;
  logic [3:0] pipe_shamt = 0;
  logic [15:0] alu_a, alu_b, alu_result, product;
  logic [2:0] alu_op;
  logic [3:0] alu_shamt;
  logic stall, done, mul_ovf;
  int n_asrt = 0, n_fail = 0;
  ex_mul_seq dut (
    .clk(clk), .rst(rst), .start(start), .mul_a(mul_a), .mul_b(mul_b),
    .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_op(pipe_op), .pipe_shamt(pipe_shamt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .stall(stall), .done(done), .product(product), .mul_ovf(mul_ovf)
  );
  always #5 clk = ~clk;
  assign alu_result = alu_op == 3'd0 ? alu_a + alu_b : alu_op == 3'd1 ? alu_a - alu_b : alu_a ^ alu_b;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_p, input logic exp_ovf, input int exp_n);
    int cyc = 0, stalls = 0;
    mul_a = a;
    mul_b = b;
    start = 1;
    #1;
    if (stall) stalls++;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
      if (stall) stalls++;
      if (cyc == 1) begin
        chk({tag, " run_alu_a"}, 32'(alu_a), 32'h0);
        chk({tag, " run_alu_b"}, 32'(alu_b), 32'(a));
        chk({tag, " run_alu_op"}, 32'(alu_op), 32'h0);
      end
    end
    chk({tag, " done_cycle"}, 32'(cyc), 32'(exp_n + 1));
    chk({tag, " stall_cycles"}, 32'(stalls), 32'(exp_n + 1));
    chk({tag, " product"}, 32'(product), 32'(exp_p));
    chk({tag, " mul_ovf"}, 32'(mul_ovf), 32'(exp_ovf));
    start = 0;
    tick();
    chk({tag, " done_pulse"}, 32'(done), 32'h0);
    chk({tag, " product_hold"}, 32'(product), 32'(exp_p));
    chk({tag, " ovf_hold"}, 32'(mul_ovf), 32'(exp_ovf));
  endtask
  initial begin
    tick();
    tick();
    chk("reset done", 32'(done), 32'h0);
    chk("reset product", 32'(product), 32'h0);
    chk("reset mul_ovf", 32'(mul_ovf), 32'h0);
    chk("reset stall", 32'(stall), 32'h0);
    rst = 0;
    tick();
    run_mul("3x5", 16'd3, 16'd5, 16'h000F, 1'b0, 3);
    run_mul("8000x2", 16'h8000, 16'd2, 16'h0000, 1'b1, 2);
    run_mul("b0", 16'h1234, 16'd0, 16'h0000, 1'b0, 1);
    run_mul("ffx101", 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 9);
    mul_a = 16'hFFFF;
    mul_b = 16'h8000;
    start = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("abort in_run stall", 32'(stall), 32'h1);
    rst = 1;
    start = 0;
    tick();
    chk("abort stall", 32'(stall), 32'h0);
    chk("abort done", 32'(done), 32'h0);
    chk("abort product", 32'(product), 32'h0);
    chk("abort mul_ovf", 32'(mul_ovf), 32'h0);
    rst = 0;
    tick();
    run_mul("post_abort 3x5", 16'd3, 16'd5, 16'h000F, 1'b0, 3);
    pipe_op = 3'd1;
    pipe_a = 16'd7;
    pipe_b = 16'd2;
    pipe_shamt = 4'd3;
    #1;
    chk("pass alu_a", 32'(alu_a), 32'd7);
    chk("pass alu_b", 32'(alu_b), 32'd2);
    chk("pass alu_op", 32'(alu_op), 32'd1);
    chk("pass alu_shamt", 32'(alu_shamt), 32'd3);
    chk("pass alu_result", 32'(alu_result), 32'd5);
    chk("pass stall", 32'(stall), 32'h0);
    run_mul("6x7", 16'd6, 16'd7, 16'h002A, 1'b0, 3);
    run_mul("ffffxffff", 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 16);
    chk("after alu_op", 32'(alu_op), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
